// File: rtl/voice_bank_pkg.sv
// voice_bank shared types: envelope states, wave select bits,
// register addresses and noise LFSR definition.
package voice_bank_pkg;

  typedef enum logic [2:0] {
    ENV_IDLE,
    ENV_ATTACK,
    ENV_DECAY,
    ENV_SUSTAIN,
    ENV_RELEASE
  } env_state_e;

  localparam int WS_SAW    = 0;
  localparam int WS_SQUARE = 1;
  localparam int WS_TRI    = 2;
  localparam int WS_NOISE  = 3;
  localparam int WS_RING   = 4;

  localparam logic [2:0] CFG_PITCH   = 3'd0;
  localparam logic [2:0] CFG_WAVE    = 3'd1;
  localparam logic [2:0] CFG_ATTACK  = 3'd2;
  localparam logic [2:0] CFG_DECAY   = 3'd3;
  localparam logic [2:0] CFG_SUSTAIN = 3'd4;
  localparam logic [2:0] CFG_RELEASE = 3'd5;
  localparam logic [2:0] CFG_GATE    = 3'd6;

  localparam int LFSR_W = 15;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 15'h0001;
  localparam int LFSR_TAP_HI = 14;
  localparam int LFSR_TAP_LO = 13;

  function automatic logic [LFSR_W-1:0] lfsr_next(
    input logic [LFSR_W-1:0] s
  );
    return {s[LFSR_W-2:0], s[LFSR_TAP_HI] ^ s[LFSR_TAP_LO]};
  endfunction

endpackage

// File: rtl/voice_env.sv
// voice_env: combinational ADSR step for one voice, one sample.
// A rate of zero jumps straight to the phase target.
module voice_env
  import voice_bank_pkg::*;
#(
  parameter int ENVWIDTH = 8
) (
  input  env_state_e          st_i,
  input  logic [ENVWIDTH-1:0] lvl_i,
  input  logic                gate_i,
  input  logic                pgate_i,
  input  logic [ENVWIDTH-1:0] atk_i,
  input  logic [ENVWIDTH-1:0] dec_i,
  input  logic [ENVWIDTH-1:0] sus_i,
  input  logic [ENVWIDTH-1:0] rel_i,
  output env_state_e          st_o,
  output logic [ENVWIDTH-1:0] lvl_o
);

  localparam logic [ENVWIDTH-1:0] LMAX = '1;

  env_state_e        st_e;
  logic [ENVWIDTH:0] up;

  always_comb begin
    st_e = st_i;
    if (gate_i && !pgate_i) begin
      st_e = ENV_ATTACK;
    end else if (!gate_i && (st_i == ENV_ATTACK ||
                             st_i == ENV_DECAY ||
                             st_i == ENV_SUSTAIN)) begin
      st_e = ENV_RELEASE;
    end
    up    = {1'b0, lvl_i} + {1'b0, atk_i};
    st_o  = st_e;
    lvl_o = lvl_i;
    case (st_e)
      ENV_ATTACK: begin
        if (atk_i == '0 || up >= {1'b0, LMAX}) begin
          lvl_o = LMAX;
          st_o  = ENV_DECAY;
        end else begin
          lvl_o = up[ENVWIDTH-1:0];
        end
      end
      ENV_DECAY: begin
        if (dec_i == '0 || lvl_i <= sus_i ||
            (lvl_i - sus_i) <= dec_i) begin
          lvl_o = sus_i;
          st_o  = ENV_SUSTAIN;
        end else begin
          lvl_o = lvl_i - dec_i;
        end
      end
      ENV_SUSTAIN: lvl_o = sus_i;
      ENV_RELEASE: begin
        if (rel_i == '0 || lvl_i <= rel_i) begin
          lvl_o = '0;
          st_o  = ENV_IDLE;
        end else begin
          lvl_o = lvl_i - rel_i;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/voice_bank.sv
// voice_bank: time-multiplexed oscillator/ADSR bank with saturating mix.
// Define VOICE_BANK_RINGMOD_EN to store wave_select bit4 (triangle ring mod).
module voice_bank
  import voice_bank_pkg::*;
#(
  parameter int NVOICES    = 4,
  parameter int BITDEPTH   = 14,
  parameter int ACCWIDTH   = 24,
  parameter int PITCHWIDTH = 21,
  parameter int ENVWIDTH   = 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       sample_clock,
  input  logic                       cfg_we,
  input  logic [$clog2(NVOICES)-1:0] cfg_voice,
  input  logic [2:0]                 cfg_addr,
  input  logic [PITCHWIDTH-1:0]      cfg_wdata,
  output logic [BITDEPTH-1:0]        out,
  output logic                       out_valid,
  output logic                       busy
);

  localparam int VW  = $clog2(NVOICES);
  localparam int MW  = BITDEPTH + VW;
  localparam int CW  = VW + 2;
  localparam int PRW = BITDEPTH + ENVWIDTH + 1;
`ifdef VOICE_BANK_RINGMOD_EN
  localparam int WSW = WS_RING + 1;
`else
  localparam int WSW = WS_RING;
`endif
  localparam logic [CW-1:0] LAST = CW'(NVOICES + 1);
  localparam logic signed [MW-1:0] SMAX = MW'(2**(BITDEPTH-1) - 1);
  localparam logic signed [MW-1:0] SMIN = ~SMAX;

  logic sc1_q, sc1_d, sc2_q, sc2_d;
  logic busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic s2_vld_q, s2_vld_d, s3_vld_q, s3_vld_d;
  logic signed [BITDEPTH-1:0] s2_wave_q, s2_wave_d;
  logic [ENVWIDTH-1:0] s2_lvl_q, s2_lvl_d;
  logic signed [BITDEPTH-1:0] s3_amp_q, s3_amp_d;
  logic signed [MW-1:0] mix_q, mix_d;
  logic [BITDEPTH-1:0] out_q, out_d;
  logic ov_q, ov_d;

  logic [ACCWIDTH-1:0]   acc_q [NVOICES];
  logic [ACCWIDTH-1:0]   acc_d [NVOICES];
  logic [PITCHWIDTH-1:0] pitch_q [NVOICES];
  logic [PITCHWIDTH-1:0] pitch_d [NVOICES];
  logic [WSW-1:0]        wsel_q [NVOICES];
  logic [WSW-1:0]        wsel_d [NVOICES];
  logic [ENVWIDTH-1:0]   atk_q [NVOICES];
  logic [ENVWIDTH-1:0]   atk_d [NVOICES];
  logic [ENVWIDTH-1:0]   dec_q [NVOICES];
  logic [ENVWIDTH-1:0]   dec_d [NVOICES];
  logic [ENVWIDTH-1:0]   sus_q [NVOICES];
  logic [ENVWIDTH-1:0]   sus_d [NVOICES];
  logic [ENVWIDTH-1:0]   rel_q [NVOICES];
  logic [ENVWIDTH-1:0]   rel_d [NVOICES];
  logic                  gate_q [NVOICES];
  logic                  gate_d [NVOICES];
  logic                  pgate_q [NVOICES];
  logic                  pgate_d [NVOICES];
  logic [ENVWIDTH-1:0]   lvl_q [NVOICES];
  logic [ENVWIDTH-1:0]   lvl_d [NVOICES];
  env_state_e            st_q [NVOICES];
  env_state_e            st_d [NVOICES];

  logic                       start;
  logic                       s1_vld;
  logic [VW-1:0]              s1_v;
  logic [ACCWIDTH-1:0]        s1_acc;
  logic [LFSR_W-1:0]          lfsr_nx;
  logic [WSW-1:0]             sel;
  logic [BITDEPTH-1:0]        top, raw;
  logic                       msb, fold_msb;
  logic signed [BITDEPTH-1:0] wave;
  env_state_e                 env_st;
  logic [ENVWIDTH-1:0]        env_lvl;
  logic signed [PRW-1:0]      prod;
  logic signed [MW-1:0]       mix_sum;
  logic [BITDEPTH-1:0]        sat;

  assign start   = sc1_q & ~sc2_q & ~busy_q;
  assign s1_vld  = busy_q && (cnt_q < CW'(NVOICES));
  assign s1_v    = cnt_q[VW-1:0];
  assign s1_acc  = acc_q[s1_v] + ACCWIDTH'(pitch_q[s1_v]);
  assign lfsr_nx = lfsr_next(lfsr_q);

  voice_env #(.ENVWIDTH(ENVWIDTH)) u_env (
    .st_i   (st_q[s1_v]),
    .lvl_i  (lvl_q[s1_v]),
    .gate_i (gate_q[s1_v]),
    .pgate_i(pgate_q[s1_v]),
    .atk_i  (atk_q[s1_v]),
    .dec_i  (dec_q[s1_v]),
    .sus_i  (sus_q[s1_v]),
    .rel_i  (rel_q[s1_v]),
    .st_o   (env_st),
    .lvl_o  (env_lvl)
  );

  // S1 waveform: raw shapes are offset binary, ANDed, then MSB flipped
  always_comb begin
    sel      = wsel_q[s1_v];
    top      = s1_acc[ACCWIDTH-1 -: BITDEPTH];
    msb      = s1_acc[ACCWIDTH-1];
    fold_msb = msb;
`ifdef VOICE_BANK_RINGMOD_EN
    if (sel[WS_RING]) begin
      fold_msb = msb ^ acc_q[s1_v - VW'(1)][ACCWIDTH-1];
    end
`endif
    raw = '1;
    if (sel[WS_SAW])    raw = raw & top;
    if (sel[WS_SQUARE]) raw = raw & {BITDEPTH{msb}};
    if (sel[WS_TRI])    raw = raw & ((top ^ {BITDEPTH{fold_msb}}) << 1);
    if (sel[WS_NOISE])  raw = raw & lfsr_nx[LFSR_W-1 -: BITDEPTH];
    if (sel[WS_NOISE:WS_SAW] == '0) begin
      wave = '0;
    end else begin
      wave = {~raw[BITDEPTH-1], raw[BITDEPTH-2:0]};
    end
  end

  assign prod = PRW'(s2_wave_q) * PRW'($signed({1'b0, s2_lvl_q}));
  assign mix_sum = mix_q + {{VW{s3_amp_q[BITDEPTH-1]}}, s3_amp_q};

  always_comb begin
    sc1_d     = sample_clock;
    sc2_d     = sc1_q;
    s2_vld_d  = s1_vld;
    s2_wave_d = wave;
    s2_lvl_d  = env_lvl;
    s3_vld_d  = s2_vld_q;
    s3_amp_d  = BITDEPTH'(prod >>> ENVWIDTH);
    lfsr_d    = s1_vld ? lfsr_nx : lfsr_q;
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    mix_d     = mix_q;
    out_d     = out_q;
    ov_d      = 1'b0;
    if (mix_sum > SMAX) begin
      sat = SMAX[BITDEPTH-1:0];
    end else if (mix_sum < SMIN) begin
      sat = SMIN[BITDEPTH-1:0];
    end else begin
      sat = mix_sum[BITDEPTH-1:0];
    end
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      mix_d  = '0;
    end else if (busy_q) begin
      cnt_d = cnt_q + CW'(1);
      if (s3_vld_q) mix_d = mix_sum;
      if (cnt_q == LAST) begin
        busy_d = 1'b0;
        ov_d   = 1'b1;
        out_d  = sat;
      end
    end
  end

  // config writes never collide with S1: S1 only touches voice state
  always_comb begin
    acc_d   = acc_q;
    pitch_d = pitch_q;
    wsel_d  = wsel_q;
    atk_d   = atk_q;
    dec_d   = dec_q;
    sus_d   = sus_q;
    rel_d   = rel_q;
    gate_d  = gate_q;
    pgate_d = pgate_q;
    lvl_d   = lvl_q;
    st_d    = st_q;
    if (cfg_we) begin
      case (cfg_addr)
        CFG_PITCH:   pitch_d[cfg_voice] = cfg_wdata;
        CFG_WAVE:    wsel_d[cfg_voice]  = cfg_wdata[WSW-1:0];
        CFG_ATTACK:  atk_d[cfg_voice]   = cfg_wdata[ENVWIDTH-1:0];
        CFG_DECAY:   dec_d[cfg_voice]   = cfg_wdata[ENVWIDTH-1:0];
        CFG_SUSTAIN: sus_d[cfg_voice]   = cfg_wdata[ENVWIDTH-1:0];
        CFG_RELEASE: rel_d[cfg_voice]   = cfg_wdata[ENVWIDTH-1:0];
        CFG_GATE:    gate_d[cfg_voice]  = cfg_wdata[0];
        default: ;
      endcase
    end
    if (s1_vld) begin
      acc_d[s1_v]   = s1_acc;
      lvl_d[s1_v]   = env_lvl;
      st_d[s1_v]    = env_st;
      pgate_d[s1_v] = gate_q[s1_v];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sc1_q     <= 1'b0;
      sc2_q     <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      lfsr_q    <= LFSR_SEED;
      s2_vld_q  <= 1'b0;
      s2_wave_q <= '0;
      s2_lvl_q  <= '0;
      s3_vld_q  <= 1'b0;
      s3_amp_q  <= '0;
      mix_q     <= '0;
      out_q     <= '0;
      ov_q      <= 1'b0;
      for (int i = 0; i < NVOICES; i++) begin
        acc_q[i]   <= '0;
        pitch_q[i] <= '0;
        wsel_q[i]  <= '0;
        atk_q[i]   <= '0;
        dec_q[i]   <= '0;
        sus_q[i]   <= '0;
        rel_q[i]   <= '0;
        gate_q[i]  <= 1'b0;
        pgate_q[i] <= 1'b0;
        lvl_q[i]   <= '0;
        st_q[i]    <= ENV_IDLE;
      end
    end else begin
      sc1_q     <= sc1_d;
      sc2_q     <= sc2_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      lfsr_q    <= lfsr_d;
      s2_vld_q  <= s2_vld_d;
      s2_wave_q <= s2_wave_d;
      s2_lvl_q  <= s2_lvl_d;
      s3_vld_q  <= s3_vld_d;
      s3_amp_q  <= s3_amp_d;
      mix_q     <= mix_d;
      out_q     <= out_d;
      ov_q      <= ov_d;
      acc_q     <= acc_d;
      pitch_q   <= pitch_d;
      wsel_q    <= wsel_d;
      atk_q     <= atk_d;
      dec_q     <= dec_d;
      sus_q     <= sus_d;
      rel_q     <= rel_d;
      gate_q    <= gate_d;
      pgate_q   <= pgate_d;
      lvl_q     <= lvl_d;
      st_q      <= st_d;
    end
  end

  assign out       = out_q;
  assign out_valid = ov_q;
  assign busy      = busy_q;

endmodule
